// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Sequencer for a direct-mapped, write-through, no-write-allocate
//               data cache. Handles one CPU load/store at a time, performs the
//               tag lookup against the external register array, refills missed
//               blocks from memory in 64-bit beats and merges store hits.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller #(
  parameter int double_word_offset_width = 3,
  parameter int line_width               = 6
) (
  input  logic                                            clock,
  input  logic                                            reset,
  // CPU request / response
  input  logic                                            req_valid,
  output logic                                            req_ready,
  input  logic [31:0]                                     req_addr,
  input  logic                                            req_write,
  input  logic [63:0]                                     req_wdata,
  input  logic [7:0]                                      req_wstrb,
  output logic                                            resp_valid,
  input  logic                                            resp_ready,
  output logic [63:0]                                     resp_data,
  // Memory port
  output logic                                            mem_req_valid,
  input  logic                                            mem_req_ready,
  output logic [31:0]                                     mem_req_addr,
  output logic                                            mem_req_write,
  output logic [63:0]                                     mem_req_wdata,
  output logic [7:0]                                      mem_req_wstrb,
  input  logic                                            mem_resp_valid,
  input  logic [63:0]                                     mem_resp_data,
  // Register array
  output logic [31:0]                                     cache_address,
  input  logic [63:0]                                     cache_data,
  input  logic [31-double_word_offset_width-3-line_width:0] cache_tag,
  input  logic                                            cache_tag_valid,
  output logic                                            cache_reset,
  output logic                                            cache_write_in,
  output logic [line_width-1:0]                           cache_write_line_index,
  output logic [31-double_word_offset_width-3-line_width:0] cache_write_tag,
  output logic [64*(1<<double_word_offset_width)-1:0]     cache_write_block,
  output logic [(1<<double_word_offset_width)-1:0]        cache_write_mask
);

  localparam int c_block_size = 1 << double_word_offset_width;
  localparam int c_tag_width  = 32 - double_word_offset_width - 3 - line_width;
  localparam int c_line_lsb   = double_word_offset_width + 3;
  localparam logic [double_word_offset_width-1:0] c_last_beat = '1;

  typedef enum logic [3:0] {
    S_FLUSH        = 4'd0,
    S_IDLE         = 4'd1,
    S_LOOKUP       = 4'd2,
    S_STORE_REQ    = 4'd3,
    S_STORE_WAIT   = 4'd4,
    S_REFILL_REQ   = 4'd5,
    S_REFILL       = 4'd6,
    S_REFILL_WRITE = 4'd7,
    S_RESP         = 4'd8
  } state_t;

  state_t                              r_state;
  state_t                              w_state_next;
  logic [31:0]                         r_addr;
  logic                                r_write;
  logic [63:0]                         r_wdata;
  logic [7:0]                          r_wstrb;
  logic [63:0]                         r_resp_data;
  logic [double_word_offset_width-1:0] r_beat_cnt;
  logic [63:0]                         r_buffer [c_block_size];

  logic [double_word_offset_width-1:0] w_dw_offset;
  logic                                w_hit;
  logic [63:0]                         w_merged;
  logic [c_block_size-1:0]             w_onehot;

  assign w_dw_offset = r_addr[c_line_lsb-1:3];
  assign w_hit       = cache_tag_valid && (cache_tag == r_addr[31 -: c_tag_width]);

  // Store data merged byte-wise over the double word currently held by the array
  for (genvar b = 0; b < 8; b++) begin : g_merge
    assign w_merged[8*b +: 8] = r_wstrb[b] ? r_wdata[8*b +: 8] : cache_data[8*b +: 8];
  end

  // Refill writes the whole buffer; a store hit only enables its own lane
  for (genvar l = 0; l < c_block_size; l++) begin : g_block_lane
    assign cache_write_block[64*l +: 64] = (r_state == S_REFILL_WRITE) ? r_buffer[l] : w_merged;
  end

  // Lane-select mask for a store hit
  always_comb begin
    w_onehot              = '0;
    w_onehot[w_dw_offset] = 1'b1;
  end

  assign cache_write_line_index = r_addr[c_line_lsb +: line_width];
  assign cache_write_tag        = r_addr[31 -: c_tag_width];
  assign cache_address          = (r_state == S_IDLE) ? req_addr : r_addr;
  assign resp_data              = r_resp_data;
  assign mem_req_addr           = r_write ? {r_addr[31:3], 3'b000}
                                          : {r_addr[31:c_line_lsb], {c_line_lsb{1'b0}}};
  assign mem_req_wdata          = r_wdata;
  assign mem_req_wstrb          = r_wstrb;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FLUSH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control output decode
  always_comb begin
    w_state_next     = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    cache_reset      = 1'b0;
    cache_write_in   = 1'b0;
    cache_write_mask = '0;
    case (r_state)
      S_FLUSH: begin
        cache_reset  = 1'b1;
        w_state_next = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (r_write) begin
          if (w_hit) begin
            cache_write_in   = 1'b1;
            cache_write_mask = w_onehot;
          end
          w_state_next = S_STORE_REQ;
        end else if (w_hit) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_REFILL_REQ;
        end
      end
      S_STORE_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        if (mem_req_ready) begin
          w_state_next = S_STORE_WAIT;
        end
      end
      S_STORE_WAIT: begin
        if (mem_resp_valid) begin
          w_state_next = S_RESP;
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_resp_valid && (r_beat_cnt == c_last_beat)) begin
          w_state_next = S_REFILL_WRITE;
        end
      end
      S_REFILL_WRITE: begin
        cache_write_in   = 1'b1;
        cache_write_mask = '1;
        w_state_next     = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_FLUSH;
      end
    endcase
  end

  // Saved request, beat counter and response data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_resp_data <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
          end
        end
        S_LOOKUP: begin
          if (!r_write && w_hit) begin
            r_resp_data <= cache_data;
          end
        end
        S_STORE_WAIT: begin
          if (mem_resp_valid) begin
            r_resp_data <= '0;
          end
        end
        S_REFILL_REQ: begin
          if (mem_req_ready) begin
            r_beat_cnt <= '0;
          end
        end
        S_REFILL: begin
          if (mem_resp_valid && (r_beat_cnt != c_last_beat)) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        S_REFILL_WRITE: begin
          // Requested double word comes straight from the refill buffer
          r_resp_data <= r_buffer[w_dw_offset];
        end
        default: begin
        end
      endcase
    end
  end

  // Refill beat capture (pure datapath, no reset needed)
  always_ff @(posedge clock) begin
    if ((r_state == S_REFILL) && mem_resp_valid) begin
      r_buffer[r_beat_cnt] <= mem_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed self-checking bench for dcache_controller with a
//               behavioural register array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_write = 1'b0;
  logic [63:0]  req_wdata = '0;
  logic [7:0]   req_wstrb = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [63:0]  resp_data;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_req_write;
  logic [63:0]  mem_req_wdata;
  logic [7:0]   mem_req_wstrb;
  logic         mem_resp_valid = 1'b0;
  logic [63:0]  mem_resp_data = '0;
  logic [31:0]  cache_address;
  logic [63:0]  cache_data = '0;
  logic [19:0]  cache_tag = '0;
  logic         cache_tag_valid = 1'b0;
  logic         cache_reset;
  logic         cache_write_in;
  logic [5:0]   cache_write_line_index;
  logic [19:0]  cache_write_tag;
  logic [511:0] cache_write_block;
  logic [7:0]   cache_write_mask;

  int vectors = 0;
  int miscompares = 0;
  int n_flush = 0;
  int n_memreq = 0;
  int n_cwrite = 0;

  logic [63:0] m_data  [64][8];
  logic [19:0] m_tag   [64];
  logic        m_valid [64];

  dcache_controller #(.double_word_offset_width(3), .line_width(6)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cache_address(cache_address), .cache_data(cache_data),
    .cache_tag(cache_tag), .cache_tag_valid(cache_tag_valid),
    .cache_reset(cache_reset), .cache_write_in(cache_write_in),
    .cache_write_line_index(cache_write_line_index),
    .cache_write_tag(cache_write_tag), .cache_write_block(cache_write_block),
    .cache_write_mask(cache_write_mask)
  );

  always #5 clock = ~clock;

  // Register array: sync invalidate, masked block write, registered read
  always @(posedge clock) begin
    if (cache_reset) begin
      for (int i = 0; i < 64; i++) m_valid[i] <= 1'b0;
    end else if (cache_write_in) begin
      m_tag[cache_write_line_index]   <= cache_write_tag;
      m_valid[cache_write_line_index] <= 1'b1;
      for (int l = 0; l < 8; l++)
        if (cache_write_mask[l]) m_data[cache_write_line_index][l] <= cache_write_block[64*l +: 64];
    end
    cache_data      <= m_data[cache_address[11:6]][cache_address[5:3]];
    cache_tag       <= m_tag[cache_address[11:6]];
    cache_tag_valid <= m_valid[cache_address[11:6]];
  end

  // Event counters while out of reset
  always @(posedge clock) begin
    if (reset) begin
      if (cache_reset) n_flush <= n_flush + 1;
      if (mem_req_valid && mem_req_ready) n_memreq <= n_memreq + 1;
      if (cache_write_in) n_cwrite <= n_cwrite + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [7:0] s);
    int n;
    n = 0;
    req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_mem_req();
    int n;
    n = 0;
    while (!mem_req_valid && n < 10) begin tick(); n++; end
    check("mem_req_wait", mem_req_valid, 1);
  endtask

  task automatic finish_resp(input string tag, input logic [63:0] exp);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_data"}, resp_data, exp);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_done"}, resp_valid, 0);
  endtask

  task automatic grant_mem();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 64'(i);
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    int snap_req, snap_wr, snap_fl;
    logic [31:0] snap_addr;
    logic [63:0] snap_data;

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_cache_write_in", cache_write_in, 0);
    check("rst_resp_data", resp_data, 0);

    snap_fl = n_flush;
    reset = 1'b1;
    repeat (3) tick();
    check("flush_pulses", 64'(n_flush - snap_fl), 1);
    check("idle_ready", req_ready, 1);

    // Cold load 0x1008, memory stalls 3 cycles before accepting
    snap_req = n_memreq;
    send_req(32'h1008, 1'b0, '0, '0);
    wait_mem_req();
    snap_addr = mem_req_addr;
    check("refill_addr", mem_req_addr, 32'h1000);
    check("refill_write", mem_req_write, 0);
    repeat (3) tick();
    check("stall_valid", mem_req_valid, 1);
    check("stall_addr", mem_req_addr, snap_addr);
    check("stall_no_dup", 64'(n_memreq - snap_req), 0);
    grant_mem();
    send_beats(64'hA0, 8);
    check("rw_write_in", cache_write_in, 1);
    check("rw_mask", cache_write_mask, 8'hFF);
    check("rw_tag", cache_write_tag, 20'h00001);
    check("rw_line", cache_write_line_index, 6'h00);
    check("rw_lane0", cache_write_block[63:0], 64'hA0);
    check("rw_lane7", cache_write_block[511:448], 64'hA7);
    tick();
    check("cold_valid", resp_valid, 1);
    snap_data = resp_data;
    repeat (5) tick();
    check("hold_valid", resp_valid, 1);
    check("hold_data", resp_data, snap_data);
    finish_resp("cold_load", 64'hA1);
    check("cold_memreqs", 64'(n_memreq - snap_req), 1);

    // Load hit 0x1038: response visible one cycle after the accept edge
    snap_req = n_memreq;
    send_req(32'h1038, 1'b0, '0, '0);
    check("hit_lookup_resp", resp_valid, 0);
    tick();
    check("hit_resp_valid", resp_valid, 1);
    finish_resp("hit_load", 64'hA7);
    check("hit_no_memreq", 64'(n_memreq - snap_req), 0);

    // Store hit 0x1010
    send_req(32'h1010, 1'b1, 64'h11223344_55667788, 8'h0F);
    check("sh_write_in", cache_write_in, 1);
    check("sh_mask", cache_write_mask, 8'h04);
    check("sh_lane", cache_write_block[191:128], 64'h00000000_55667788);
    check("sh_tag", cache_write_tag, 20'h00001);
    tick();
    check("sh_mem_valid", mem_req_valid, 1);
    check("sh_mem_write", mem_req_write, 1);
    check("sh_mem_addr", mem_req_addr, 32'h1010);
    check("sh_mem_wstrb", mem_req_wstrb, 8'h0F);
    check("sh_mem_wdata", mem_req_wdata, 64'h11223344_55667788);
    grant_mem();
    repeat (2) tick();
    check("sh_wait_ack", resp_valid, 0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    finish_resp("store_hit", 64'h0);
    send_req(32'h1010, 1'b0, '0, '0);
    finish_resp("merged_readback", 64'h00000000_55667788);

    // Store miss 0x8000: no array write, one memory write
    snap_wr = n_cwrite;
    snap_req = n_memreq;
    send_req(32'h8000, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    check("sm_no_write", cache_write_in, 0);
    wait_mem_req();
    check("sm_mem_write", mem_req_write, 1);
    check("sm_mem_addr", mem_req_addr, 32'h8000);
    grant_mem();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    finish_resp("store_miss", 64'h0);
    check("sm_writes", 64'(n_cwrite - snap_wr), 0);
    check("sm_memreqs", 64'(n_memreq - snap_req), 1);

    // Load 0x8000 now misses (no write-allocate)
    send_req(32'h8000, 1'b0, '0, '0);
    wait_mem_req();
    check("lm_addr", mem_req_addr, 32'h8000);
    check("lm_write", mem_req_write, 0);
    grant_mem();
    send_beats(64'hB0, 8);
    finish_resp("load_8000", 64'hB0);

    // Reset during refill beat 4
    snap_wr = n_cwrite;
    send_req(32'h2000, 1'b0, '0, '0);
    wait_mem_req();
    grant_mem();
    send_beats(64'hD0, 4);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hD4;
    #2;
    reset = 1'b0;
    #1;
    check("mid_req_ready", req_ready, 0);
    check("mid_mem_req_valid", mem_req_valid, 0);
    check("mid_resp_valid", resp_valid, 0);
    check("mid_cache_write_in", cache_write_in, 0);
    check("mid_resp_data", resp_data, 0);
    mem_resp_valid = 1'b0;
    repeat (2) tick();
    snap_fl = n_flush;
    reset = 1'b1;
    repeat (3) tick();
    check("reflush_pulses", 64'(n_flush - snap_fl), 1);
    check("abandoned_no_write", 64'(n_cwrite - snap_wr), 0);

    // Previously cached 0x8008 misses after the flush
    send_req(32'h8008, 1'b0, '0, '0);
    tick();
    check("post_reset_miss", mem_req_valid, 1);
    check("post_reset_addr", mem_req_addr, 32'h8000);
    grant_mem();
    send_beats(64'hC0, 8);
    finish_resp("post_reset_load", 64'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
